div_issue_ctrl: RTL and testbench

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/riscv_core_pkg.sv | 26 ++
 rtl/div_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core types: divide-controller FSM states, M-extension funct3 codes
// and the packed request record used by the divide issue controller.
package riscv_core_pkg;

  // Divide issue controller states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2,
    StResp  = 2'd3
  } div_state_e;

  // M-extension divide/remainder funct3 encodings
  localparam logic [2:0] Funct3Div  = 3'b100;
  localparam logic [2:0] Funct3Divu = 3'b101;
  localparam logic [2:0] Funct3Rem  = 3'b110;
  localparam logic [2:0] Funct3Remu = 3'b111;

  // Operation plus operands; also the tag of the last-result cache
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } div_req_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// Divide issue controller: accepts one M-extension divide at a time from
// Execute, starts the external divider (or replays a cached identical result),
// holds the response for Writeback and handles pipeline flushes.
module div_issue_ctrl
  import riscv_core_pkg::*;
#(
  parameter bit          CACHE_EN = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             div_start_o,
  output logic [31:0]      div_a_o,
  output logic [31:0]      div_b_o,
  output logic [2:0]       div_op_o,
  input  logic [31:0]      div_result_i,
  input  logic             div_done_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o
);

  div_state_e       state_q, state_d;
  div_req_t         req_in;
  div_req_t         req_q, req_d;
  logic [31:0]      rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             cache_hit;
  logic [31:0]      cache_res;
  logic             done_load;
  logic             rsp_take;

  assign req_in = '{op: req_op_i, a: req_a_i, b: req_b_i};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush always wins over a coincident done or handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = cache_hit ? StResp : StBusy;
        end
      end
      StBusy: begin
        if (flush_i) begin
          // A done in the flush cycle retires the divider, so nothing is left to drain
          state_d = div_done_i ? StIdle : StDrain;
        end else if (div_done_i) begin
          state_d = StResp;
        end
      end
      StDrain: begin
        if (div_done_i) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (flush_i || rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and strobe decode
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    accept      = 1'b0;
    div_start_o = 1'b0;
    done_load   = 1'b0;
    rsp_take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o      = 1'b0;
        req_ready_o = !flush_i;
        accept      = req_valid_i && !flush_i;
        div_start_o = accept && !cache_hit;
      end
      StBusy: begin
        done_load = div_done_i && !flush_i;
      end
      StDrain: begin
        busy_o = 1'b1;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_take    = rsp_ready_i && !flush_i;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
    // Operands come straight from Execute in the start cycle, then from the
    // request register so the divider sees stable inputs for the whole op.
    div_a_o    = div_start_o ? req_a_i  : req_q.a;
    div_b_o    = div_start_o ? req_b_i  : req_q.b;
    div_op_o   = div_start_o ? req_op_i : req_q.op;
    rsp_data_o = rsp_q;
    op_count_o = cnt_q;
  end

  // Next values of the request, response and completed-op counter registers
  always_comb begin
    req_d = req_q;
    rsp_d = rsp_q;
    cnt_d = cnt_q;
    if (accept) begin
      req_d = req_in;
    end
    if (accept && cache_hit) begin
      rsp_d = cache_res;
    end else if (done_load) begin
      rsp_d = div_result_i;
    end
    if (rsp_take) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Request, response and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
      rsp_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      rsp_q <= rsp_d;
      cnt_q <= cnt_d;
    end
  end

  if (CACHE_EN) begin : g_cache
    logic        cache_valid_q;
    div_req_t    cache_tag_q;
    logic [31:0] cache_res_q;

    // Single-entry last-result cache, filled only by a completed, unflushed divide
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cache_valid_q <= 1'b0;
        cache_tag_q   <= '0;
        cache_res_q   <= '0;
      end else if (done_load) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= req_q;
        cache_res_q   <= div_result_i;
      end
    end

    assign cache_hit = cache_valid_q && (cache_tag_q == req_in);
    assign cache_res = cache_res_q;
  end else begin : g_no_cache
    assign cache_hit = 1'b0;
    assign cache_res = '0;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [2:0]  div_op;
  logic [31:0] div_result;
  logic        div_done;
  logic        busy;
  logic [31:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .flush_i      (flush),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .div_start_o  (div_start),
    .div_a_o      (div_a),
    .div_b_o      (div_b),
    .div_op_o     (div_op),
    .div_result_i (div_result),
    .div_done_i   (div_done),
    .busy_o       (busy),
    .op_count_o   (op_count)
  );

  // RISC-V M-extension divide semantics
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa;
    int signed sb;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'b101:  ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  ref_div = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      3'b111:  ref_div = (b == 0) ? a : a % b;
      default: ref_div = 32'd0;
    endcase
  endfunction

  // Divider model: result appears with a done pulse `lat` cycles after start.
  // It ignores reset so that an abandoned operation can still deliver a stray done.
  int          lat = 32;
  int          dcnt = 0;
  logic [31:0] dres = '0;
  logic        inj_done = 1'b0;
  int          n_start = 0;

  always @(posedge clk) begin
    if (div_start) begin
      dcnt    <= lat;
      dres    <= ref_div(div_op, div_a, div_b);
      n_start <= n_start + 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign div_done   = (dcnt == 1) || inj_done;
  assign div_result = dres;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 0;
    flush     = 0;
    rsp_ready = 0;
    inj_done  = 0;
    rst_n     = 0;
    repeat (2) next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  // One full transaction from IDLE with rsp_ready held high; returns the response
  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output bit got);
    req_valid = 1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1;
    next_cycle();
    req_valid = 0;
    got = 0;
    res = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        res = rsp_data;
        got = 1;
        break;
      end
    end
    next_cycle();
  endtask

  // Request that must be served from the cache: no start, response next cycle
  task automatic expect_hit(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    int n0;
    n0        = n_start;
    req_valid = 1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1;
    @(negedge clk);
    chk({nm, "_accept_ready"}, req_ready, 1);
    chk({nm, "_no_start"}, div_start, 0);
    next_cycle();
    req_valid = 0;
    @(negedge clk);
    chk({nm, "_rsp_valid"}, rsp_valid, 1);
    chk({nm, "_rsp_data"}, rsp_data, exp);
    next_cycle();
    chk({nm, "_start_count"}, n_start, n0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  // Reference model phases for the randomized run
  localparam int PhFree = 0, PhComputing = 1, PhDiscarding = 2, PhHolding = 3;

  initial begin
    logic [31:0] res;
    bit          got;
    int          n0;
    int          seen;
    logic [31:0] pool_a[4];
    logic [31:0] pool_b[4];
    int          ph;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_rsp;
    bit          mc_valid;
    logic [2:0]  mc_op;
    logic [31:0] mc_a, mc_b, mc_res;
    logic [31:0] m_cnt;
    bit          exp_ready, acc, hit;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{3'b100, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA};
    vecs[3]  = '{3'b110, 32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE};
    vecs[4]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[5]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[6]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[8]  = '{3'b110, 32'd5,          32'd0,          32'd5};
    vecs[9]  = '{3'b111, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};
    vecs[10] = '{3'b101, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF};
    vecs[11] = '{3'b110, 32'd20,         32'hFFFF_FFFD,  32'd2};
    vecs[12] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};

    req_op = 0;
    req_a  = 0;
    req_b  = 0;

    // Reset values
    req_valid = 0;
    flush     = 0;
    rsp_ready = 0;
    rst_n     = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_req_ready", req_ready, 1);
    next_cycle();
    rst_n = 1;
    next_cycle();

    // DIVU 100/7 with 32-cycle divider latency
    lat       = 32;
    req_valid = 1;
    req_op    = 3'b101;
    req_a     = 32'd100;
    req_b     = 32'd7;
    rsp_ready = 1;
    @(negedge clk);
    chk("divu_start", div_start, 1);
    chk("divu_div_a", div_a, 100);
    chk("divu_div_b", div_b, 7);
    chk("divu_div_op", div_op, 3'b101);
    next_cycle();
    req_valid = 0;
    seen = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_done) begin
        seen = i;
        break;
      end
    end
    chk("divu_done_latency", seen, 31);
    chk("divu_no_early_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("divu_rsp_valid", rsp_valid, 1);
    chk("divu_rsp_data", rsp_data, 14);
    next_cycle();
    @(negedge clk);
    chk("divu_op_count", op_count, 1);
    chk("divu_idle", busy, 0);
    chk("divu_one_start", n_start, 1);
    next_cycle();

    // REM 100/7 twice: second is a cache hit
    lat = 6;
    n0  = n_start;
    run_txn(3'b110, 32'd100, 32'd7, res, got);
    chk("rem1_got", got, 1);
    chk("rem1_data", res, 2);
    chk("rem1_started", n_start, n0 + 1);
    expect_hit("rem2", 3'b110, 32'd100, 32'd7, 32'd2);
    chk("rem2_op_count", op_count, 3);

    // DIV overflow case flushed in BUSY, plus a flush while draining
    lat       = 32;
    req_valid = 1;
    req_op    = 3'b100;
    req_a     = 32'h8000_0000;
    req_b     = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("fl_start", div_start, 1);
    next_cycle();
    req_valid = 0;
    repeat (4) next_cycle();
    flush = 1;
    @(negedge clk);
    chk("fl_busy_ready", req_ready, 0);
    chk("fl_busy_rsp", rsp_valid, 0);
    next_cycle();
    flush = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i < 3 || div_done) begin
        chk("fl_drain_busy", busy, 1);
        chk("fl_drain_rsp", rsp_valid, 0);
        chk("fl_drain_ready", req_ready, 0);
      end
      if (div_done) begin
        seen = 1;
        break;
      end
      next_cycle();
      flush = (i == 2);
    end
    chk("fl_done_seen", seen, 1);
    next_cycle();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_after_idle", busy, 0);
      chk("fl_after_rsp", rsp_valid, 0);
      next_cycle();
    end
    chk("fl_op_count", op_count, 3);
    expect_hit("fl_cache_kept", 3'b110, 32'd100, 32'd7, 32'd2);

    // DIV -20/3 with Writeback stalled for 10 cycles
    lat       = 8;
    req_valid = 1;
    req_op    = 3'b100;
    req_a     = 32'hFFFF_FFEC;
    req_b     = 32'd3;
    rsp_ready = 0;
    @(negedge clk);
    chk("stall_start", div_start, 1);
    next_cycle();
    req_op = 3'b101;
    req_a  = 32'd1;
    req_b  = 32'd1;
    seen   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("stall_rsp_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, 32'hFFFF_FFFA);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_no_start", div_start, 0);
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    req_valid = 0;
    rsp_ready = 1;
    next_cycle();
    @(negedge clk);
    chk("stall_idle", busy, 0);
    chk("stall_op_count", op_count, 5);
    next_cycle();

    // Reset in BUSY, then stray done pulses
    lat       = 20;
    req_valid = 1;
    req_op    = 3'b101;
    req_a     = 32'd1000;
    req_b     = 32'd3;
    next_cycle();
    req_valid = 0;
    repeat (5) next_cycle();
    #2;
    rst_n = 0;
    #1;
    chk("rb_busy", busy, 0);
    chk("rb_rsp_valid", rsp_valid, 0);
    chk("rb_rsp_data", rsp_data, 0);
    chk("rb_op_count", op_count, 0);
    chk("rb_div_start", div_start, 0);
    next_cycle();
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      inj_done = (i == 3);
      @(negedge clk);
      chk("rb_stray_busy", busy, 0);
      chk("rb_stray_rsp", rsp_valid, 0);
      next_cycle();
    end
    inj_done = 0;
    chk("rb_op_count_after", op_count, 0);
    lat = 4;
    n0  = n_start;
    run_txn(3'b100, 32'hFFFF_FFEC, 32'd3, res, got);
    chk("rb_cache_cleared", n_start, n0 + 1);
    chk("rb_data", res, 32'hFFFF_FFFA);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      lat = 2 + i;
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, res, got);
      chk($sformatf("vec%0d_got", i), got, 1);
      chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
    end

    // Randomized run against the reference model
    do_reset();
    pool_a[0] = 32'h8000_0000;
    pool_a[1] = 32'hFFFF_FFEC;
    pool_a[2] = 32'd100;
    pool_a[3] = $urandom;
    pool_b[0] = 32'd0;
    pool_b[1] = 32'd3;
    pool_b[2] = 32'hFFFF_FFFF;
    pool_b[3] = 32'd7;
    ph       = PhFree;
    mc_valid = 0;
    m_cnt    = 0;
    m_op = 0; m_a = 0; m_b = 0; m_rsp = 0;
    mc_op = 0; mc_a = 0; mc_b = 0; mc_res = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 70) begin
        req_op = 3'b100 | 3'($urandom_range(0, 3));
        req_a  = pool_a[$urandom_range(0, 3)];
        req_b  = pool_b[$urandom_range(0, 3)];
      end
      flush     = ($urandom_range(0, 99) < 6);
      rsp_ready = ($urandom_range(0, 99) < 50);
      inj_done  = (ph == PhFree || ph == PhHolding) && ($urandom_range(0, 99) < 5);
      lat       = $urandom_range(1, 6);
      @(negedge clk);
      exp_ready = (ph == PhFree) && !flush;
      acc       = req_valid && exp_ready;
      hit       = acc && mc_valid && mc_op == req_op && mc_a == req_a && mc_b == req_b;
      chk("rnd_req_ready", req_ready, exp_ready);
      chk("rnd_div_start", div_start, acc && !hit);
      chk("rnd_rsp_valid", rsp_valid, ph == PhHolding);
      chk("rnd_busy", busy, ph != PhFree);
      chk("rnd_op_count", op_count, m_cnt);
      if (ph == PhHolding) chk("rnd_rsp_data", rsp_data, m_rsp);
      if (acc && !hit) begin
        chk("rnd_start_a", div_a, req_a);
        chk("rnd_start_b", div_b, req_b);
        chk("rnd_start_op", div_op, req_op);
      end
      if (ph == PhComputing) begin
        chk("rnd_hold_a", div_a, m_a);
        chk("rnd_hold_op", div_op, m_op);
      end
      case (ph)
        PhFree: begin
          if (acc) begin
            m_op = req_op;
            m_a  = req_a;
            m_b  = req_b;
            if (hit) begin
              m_rsp = mc_res;
              ph    = PhHolding;
            end else begin
              ph = PhComputing;
            end
          end
        end
        PhComputing: begin
          if (flush) begin
            ph = div_done ? PhFree : PhDiscarding;
          end else if (div_done) begin
            m_rsp    = ref_div(m_op, m_a, m_b);
            mc_valid = 1;
            mc_op    = m_op;
            mc_a     = m_a;
            mc_b     = m_b;
            mc_res   = m_rsp;
            ph       = PhHolding;
          end
        end
        PhDiscarding: begin
          if (div_done) ph = PhFree;
        end
        default: begin
          if (flush) begin
            ph = PhFree;
          end else if (rsp_ready) begin
            m_cnt = m_cnt + 1;
            ph    = PhFree;
          end
        end
      endcase
      next_cycle();
    end
    inj_done = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
